// File: rtl/hash_pkg.sv
// Shared constants and state encoding for the hash-search front end.
package hash_pkg;
  localparam int NONCE_W   = 32;
  localparam int LANES_MAX = 4;
  localparam int TARGET_W  = 8;
  localparam int RANK_W    = $clog2(LANES_MAX + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/lane_rank.sv
// Prefix count over a lane request vector: per-lane rank (requesters below it)
// and the total number of requesters.
module lane_rank
  import hash_pkg::*;
#(
  parameter int LANES = hash_pkg::LANES_MAX
) (
  input  logic [LANES-1:0]        need,
  output logic [LANES*RANK_W-1:0] rank,
  output logic [RANK_W-1:0]       total
);

  logic [RANK_W-1:0] acc;

  always_comb begin
    acc  = '0;
    rank = '0;
    for (int i = 0; i < LANES; i++) begin
      rank[i*RANK_W +: RANK_W] = acc;
      acc = acc + RANK_W'(need[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Hands out strictly increasing nonces to up to LANES hash lanes and latches
// the search parameters; stops on a hit or when the nonce space runs out.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | refilling lanes, counting cycles
// DONE  | search ended (fin or exhausted), waiting for start
module nonce_dispatcher #(
  parameter int LANES   = 4,
  parameter int NONCE_W = 32
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic                          start,
  input  logic [1:0]                    num_entradas,
  input  logic [hash_pkg::TARGET_W-1:0] target,
  input  logic [NONCE_W-1:0]            nonce_inicio,
  input  logic [LANES-1:0]              lane_ready,
  input  logic                          fin_in,
  input  logic [NONCE_W-1:0]            nonce_valido_in,
  output logic [LANES-1:0]              nonce_valid,
  output logic [LANES*NONCE_W-1:0]      nonce_bus,
  output logic [hash_pkg::TARGET_W-1:0] target_out,
  output logic                          busy,
  output logic                          fin,
  output logic                          exhausted,
  output logic [NONCE_W-1:0]            nonce_valido_out,
  output logic [31:0]                   ciclos
);
  import hash_pkg::*;

  state_t                     state;
  logic [LANES-1:0]           active;
  logic [NONCE_W:0]           next_nonce;

  logic [LANES-1:0]           start_mask;
  logic [LANES-1:0]           xfer;
  logic [LANES-1:0]           need;
  logic [LANES-1:0]           fill;
  logic [NONCE_W:0]           base;
  logic [NONCE_W:0]           next_sum;
  logic [LANES*RANK_W-1:0]    rank;
  logic [RANK_W-1:0]          total;
  logic [LANES-1:0][NONCE_W:0] fill_val;
  logic                       exhaust;

  always_comb begin
    start_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      start_mask[i] = (i <= int'(num_entradas));
    end
  end

  // The start fill and the RUN refill share one rank/overflow path.
  assign xfer     = nonce_valid & lane_ready;
  assign base     = (state == RUN) ? next_nonce : {1'b0, nonce_inicio};
  assign need     = (state == RUN) ? (active & (~nonce_valid | xfer)) : start_mask;
  assign next_sum = base + (NONCE_W+1)'(total);

  lane_rank #(.LANES(LANES)) u_lane_rank (
    .need  (need),
    .rank  (rank),
    .total (total)
  );

  // Bit NONCE_W of a fill value set means it lies past the last nonce.
  always_comb begin
    fill_val = '0;
    fill     = '0;
    for (int i = 0; i < LANES; i++) begin
      fill_val[i] = base + (NONCE_W+1)'(rank[i*RANK_W +: RANK_W]);
      fill[i]     = need[i] & ~fill_val[i][NONCE_W];
    end
  end

  assign exhaust = |(need & ~fill);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state            <= IDLE;
      active           <= '0;
      next_nonce       <= '0;
      nonce_valid      <= '0;
      nonce_bus        <= '0;
      target_out       <= '0;
      busy             <= 1'b0;
      fin              <= 1'b0;
      exhausted        <= 1'b0;
      nonce_valido_out <= '0;
      ciclos           <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            active      <= start_mask;
            target_out  <= target;
            fin         <= 1'b0;
            exhausted   <= 1'b0;
            ciclos      <= '0;
            busy        <= 1'b1;
            next_nonce  <= next_sum;
            nonce_valid <= fill;
            for (int i = 0; i < LANES; i++) begin
              if (fill[i]) nonce_bus[i*NONCE_W +: NONCE_W] <= fill_val[i][NONCE_W-1:0];
            end
          end
        end
        RUN: begin
          if (ciclos != '1) ciclos <= ciclos + 32'd1;
          if (fin_in) begin
            state            <= DONE;
            fin              <= 1'b1;
            nonce_valido_out <= nonce_valido_in;
            nonce_valid      <= '0;
            busy             <= 1'b0;
          end else if (exhaust) begin
            state       <= DONE;
            exhausted   <= 1'b1;
            nonce_valid <= '0;
            busy        <= 1'b0;
          end else begin
            next_nonce <= next_sum;
            for (int i = 0; i < LANES; i++) begin
              if (need[i]) begin
                nonce_valid[i]                  <= 1'b1;
                nonce_bus[i*NONCE_W +: NONCE_W] <= fill_val[i][NONCE_W-1:0];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed bench for nonce_dispatcher: a nonce-queue model checked every cycle
// plus literal expectations taken from the hand-worked scenarios.
module tb_nonce_dispatcher;
  localparam longint unsigned MAXN = 64'hFFFF_FFFF;

  logic         clk;
  logic         reset_L;
  logic         start;
  logic [1:0]   num_entradas;
  logic [7:0]   target;
  logic [31:0]  nonce_inicio;
  logic [3:0]   lane_ready;
  logic         fin_in;
  logic [31:0]  nonce_valido_in;
  logic [3:0]   nonce_valid;
  logic [127:0] nonce_bus;
  logic [7:0]   target_out;
  logic         busy;
  logic         fin;
  logic         exhausted;
  logic [31:0]  nonce_valido_out;
  logic [31:0]  ciclos;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  nonce_dispatcher #(.LANES(4), .NONCE_W(32)) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .start            (start),
    .num_entradas     (num_entradas),
    .target           (target),
    .nonce_inicio     (nonce_inicio),
    .lane_ready       (lane_ready),
    .fin_in           (fin_in),
    .nonce_valido_in  (nonce_valido_in),
    .nonce_valid      (nonce_valid),
    .nonce_bus        (nonce_bus),
    .target_out       (target_out),
    .busy             (busy),
    .fin              (fin),
    .exhausted        (exhausted),
    .nonce_valido_out (nonce_valido_out),
    .ciclos           (ciclos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane(input int i);
    return nonce_bus[i*32 +: 32];
  endfunction

  // Model: the search is a single counter handing its next values to whichever
  // active lanes are empty or just consumed, in lane order.
  bit               m_run = 0;
  longint unsigned  m_next = 0;
  bit               m_valid[4] = '{default: 0};
  longint unsigned  m_bus[4] = '{default: 0};
  int               m_nact = 0;
  bit               m_fin = 0;
  bit               m_exh = 0;
  logic [31:0]      m_vout = '0;
  logic [31:0]      m_cic = '0;
  logic [7:0]       m_tgt = '0;

  task automatic model_reset();
    m_run = 0; m_next = 0; m_nact = 0; m_fin = 0; m_exh = 0;
    m_vout = '0; m_cic = '0; m_tgt = '0;
    for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_bus[i] = 0; end
  endtask

  task automatic model_step();
    bit              nv[4];
    longint unsigned nb[4];
    int              taken;
    bit              ex;
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_tgt = target; m_fin = 0; m_exh = 0; m_cic = '0;
        m_nact = (int'(num_entradas) + 1 > 4) ? 4 : int'(num_entradas) + 1;
        for (int i = 0; i < 4; i++) begin
          m_bus[i]   = 64'(nonce_inicio) + 64'(i);
          m_valid[i] = (i < m_nact) && (m_bus[i] <= MAXN);
        end
        m_next = 64'(nonce_inicio) + 64'(m_nact);
      end
    end else begin
      if (m_cic != 32'hFFFF_FFFF) m_cic = m_cic + 32'd1;
      if (fin_in) begin
        m_run = 0; m_fin = 1; m_vout = nonce_valido_in;
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
      end else begin
        taken = 0; ex = 0;
        for (int i = 0; i < 4; i++) begin
          nv[i] = m_valid[i]; nb[i] = m_bus[i];
          if (i < m_nact && (!m_valid[i] || lane_ready[i])) begin
            if (m_next + 64'(taken) > MAXN) ex = 1;
            else begin nv[i] = 1; nb[i] = m_next + 64'(taken); end
            taken++;
          end
        end
        if (ex) begin
          m_run = 0; m_exh = 1;
          for (int i = 0; i < 4; i++) m_valid[i] = 0;
        end else begin
          for (int i = 0; i < 4; i++) begin m_valid[i] = nv[i]; m_bus[i] = nb[i]; end
          m_next = m_next + 64'(taken);
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("m_valid%0d", i), 64'(nonce_valid[i]), 64'(m_valid[i]));
        if (m_valid[i]) check($sformatf("m_bus%0d", i), 64'(lane(i)), m_bus[i]);
      end
      check("m_busy", 64'(busy), 64'(m_run));
      check("m_fin", 64'(fin), 64'(m_fin));
      check("m_exh", 64'(exhausted), 64'(m_exh));
      check("m_vout", 64'(nonce_valido_out), 64'(m_vout));
      check("m_ciclos", 64'(ciclos), 64'(m_cic));
      check("m_target", 64'(target_out), 64'(m_tgt));
    end
  end

  // One cycle of stimulus; target tracks nonce_inicio so it moves whenever
  // the parameter inputs move.
  task automatic cyc(input bit st, input logic [1:0] ne, input logic [31:0] ini,
                     input logic [3:0] rdy, input bit f, input logic [31:0] fv);
    start = st; num_entradas = ne; nonce_inicio = ini; target = ini[7:0] ^ 8'h5A;
    lane_ready = rdy; fin_in = f; nonce_valido_in = fv;
    @(negedge clk);
  endtask

  task automatic run(input logic [3:0] rdy);
    cyc(0, 2'd0, 32'h0BAD_0BAD, rdy, 0, 32'h0);
  endtask

  localparam logic [3:0] PAT [12] = '{4'h7, 4'h0, 4'h1, 4'h2, 4'h4, 4'h6,
                                      4'h5, 4'h3, 4'h7, 4'h0, 4'hF, 4'h2};

  initial begin
    reset_L = 1'b0; start = 0; num_entradas = 0; target = 0; nonce_inicio = 0;
    lane_ready = 0; fin_in = 0; nonce_valido_in = 0;
    @(negedge clk);
    check("rst_valid", 64'(nonce_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ciclos", 64'(ciclos), 64'h0);
    reset_L = 1'b1;
    chk_en = 1;

    // four lanes, everyone always ready; a start mid-run must be ignored
    cyc(1, 2'd3, 32'h100, 4'h0, 0, 0);
    check("s1_l0", 64'(lane(0)), 64'h100);
    check("s1_l3", 64'(lane(3)), 64'h103);
    check("s1_busy", 64'(busy), 64'h1);
    run(4'hF);
    cyc(1, 2'd0, 32'h999, 4'hF, 0, 0);
    check("s1_l0b", 64'(lane(0)), 64'h108);
    check("s1_l3b", 64'(lane(3)), 64'h10B);
    run(4'hF);
    check("s1_ciclos", 64'(ciclos), 64'd3);
    check("s1_l2c", 64'(lane(2)), 64'h10E);
    check("s1_target", 64'(target_out), 64'h5A);
    cyc(0, 2'd0, 32'h0, 4'h0, 1, 32'h1111_1111);

    // two lanes, lane 1 stalled
    cyc(1, 2'd1, 32'h0, 4'h0, 0, 0);
    check("s2_l0", 64'(lane(0)), 64'h0);
    repeat (4) run(4'h1);
    check("s2_l0b", 64'(lane(0)), 64'h5);
    check("s2_l1", 64'(lane(1)), 64'h1);
    check("s2_valid", 64'(nonce_valid), 64'h3);
    cyc(0, 2'd0, 32'h0, 4'h3, 1, 32'h2222_2222);

    // hit while lanes 0 and 2 transfer, then a late hit is ignored
    cyc(1, 2'd3, 32'h200, 4'h0, 0, 0);
    cyc(0, 2'd0, 32'h0, 4'h5, 1, 32'hDEAD_BEEF);
    check("s3_fin", 64'(fin), 64'h1);
    check("s3_vout", 64'(nonce_valido_out), 64'hDEAD_BEEF);
    check("s3_valid", 64'(nonce_valid), 64'h0);
    check("s3_busy", 64'(busy), 64'h0);
    cyc(0, 2'd0, 32'h0, 4'hF, 1, 32'h1234_5678);
    check("s3_vout2", 64'(nonce_valido_out), 64'hDEAD_BEEF);
    check("s3_ciclos", 64'(ciclos), 64'd1);

    // start two below the top of the nonce space
    cyc(1, 2'd3, 32'hFFFF_FFFE, 4'h0, 0, 0);
    check("s4_valid", 64'(nonce_valid), 64'h3);
    check("s4_l0", 64'(lane(0)), 64'hFFFF_FFFE);
    check("s4_l1", 64'(lane(1)), 64'hFFFF_FFFF);
    check("s4_fin_clr", 64'(fin), 64'h0);
    run(4'h0);
    check("s4_exh", 64'(exhausted), 64'h1);
    check("s4_fin", 64'(fin), 64'h0);
    check("s4_valid2", 64'(nonce_valid), 64'h0);
    check("s4_ciclos", 64'(ciclos), 64'd1);

    // hit and exhaustion on the same edge
    cyc(1, 2'd3, 32'hFFFF_FFFE, 4'h0, 0, 0);
    check("s5_exh_clr", 64'(exhausted), 64'h0);
    cyc(0, 2'd0, 32'h0, 4'h0, 1, 32'hCAFE_F00D);
    check("s5_fin", 64'(fin), 64'h1);
    check("s5_exh", 64'(exhausted), 64'h0);
    check("s5_vout", 64'(nonce_valido_out), 64'hCAFE_F00D);

    // exactly four nonces left: run holds until a lane consumes one
    cyc(1, 2'd3, 32'hFFFF_FFFC, 4'h0, 0, 0);
    check("s4b_valid", 64'(nonce_valid), 64'hF);
    check("s4b_l3", 64'(lane(3)), 64'hFFFF_FFFF);
    run(4'h0);
    check("s4b_busy", 64'(busy), 64'h1);
    run(4'h1);
    check("s4b_exh", 64'(exhausted), 64'h1);
    check("s4b_valid2", 64'(nonce_valid), 64'h0);

    // three lanes under an irregular ready pattern
    cyc(1, 2'd2, 32'h1000, 4'h0, 0, 0);
    for (int k = 0; k < 12; k++) run(PAT[k]);
    cyc(0, 2'd0, 32'h0, 4'h0, 1, 32'h3333_3333);

    // restart from DONE, then asynchronous reset mid-run
    cyc(1, 2'd0, 32'h40, 4'h0, 0, 0);
    check("s6_fin_clr", 64'(fin), 64'h0);
    check("s6_ciclos_clr", 64'(ciclos), 64'h0);
    check("s6_l0", 64'(lane(0)), 64'h40);
    run(4'h1);
    run(4'h1);
    check("s6_l0b", 64'(lane(0)), 64'h42);
    @(posedge clk);
    #2 reset_L = 1'b0;
    #1;
    check("s6_rst_valid", 64'(nonce_valid), 64'h0);
    check("s6_rst_busy", 64'(busy), 64'h0);
    check("s6_rst_ciclos", 64'(ciclos), 64'h0);
    check("s6_rst_target", 64'(target_out), 64'h0);
    check("s6_rst_bus", 64'(lane(0)), 64'h0);
    check("s6_rst_vout", 64'(nonce_valido_out), 64'h0);
    @(negedge clk);
    reset_L = 1'b1;
    cyc(1, 2'd3, 32'h700, 4'h0, 0, 0);
    check("s6_new_l0", 64'(lane(0)), 64'h700);
    check("s6_new_l3", 64'(lane(3)), 64'h703);
    run(4'hF);
    check("s6_new_l0b", 64'(lane(0)), 64'h704);
    cyc(0, 2'd0, 32'h0, 4'h0, 1, 32'h4444_4444);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
